// File: rtl/hbm_rd_arbiter_pkg.sv
// hbm_rd_arbiter_pkg: shared types and constants for the HBM read-address arbiter.
//   arb_state_t        : arbiter FSM state (StArb, StIssue)
//   MEM_RD_A/MEM_RD_B  : ARID tags used by the A/B memory-read engines
//   idx_w()            : width of a requester index for a given requester count
package hbm_rd_arbiter_pkg;

    typedef enum logic {
        StArb   = 1'b0,
        StIssue = 1'b1
    } arb_state_t;

    localparam logic [3:0] MEM_RD_A = 4'h0;
    localparam logic [3:0] MEM_RD_B = 4'h1;

    // Never returns 0 so a single-requester build still gets a legal vector width.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hbm_rr_pick.sv
// hbm_rr_pick: combinational round-robin priority pick.
//   req   : request vector, one bit per requester
//   ptr   : requester with highest priority this cycle
//   valid : at least one request present
//   idx   : first requester with req set, searching upward from ptr with wrap
module hbm_rr_pick
    import hbm_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic                        valid,
    output logic [idx_w(NUM_REQ)-1:0]   idx
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// hbm_rd_arbiter: round-robin arbiter of NUM_REQ read-address requesters onto one HBM AR
// channel, with an outstanding-burst credit limit.
//   hbm_clk, hbm_areset        : clock, asynchronous active-high reset
//   s_arvalid/araddr/arid/arlen: packed per-requester AR requests (requester i at slice i)
//   s_arready                  : one-cycle accept pulse to the granted requester
//   m_axi_AR*                  : registered AR channel; ARID = {winner index, s_arid}
//   m_axi_RVALID/RREADY/RLAST  : observed only, to retire bursts
//   outstanding                : issued-but-incomplete burst count
//   cnt_err                    : sticky, RLAST seen with nothing outstanding
// Build option HBM_RD_ARB_DEBUG_CNT_EN adds grant_cnt (32 bits per requester) and
// stall_cnt (cycles a valid request was blocked by the credit limit).
module hbm_rd_arbiter
    import hbm_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 33,
    parameter int unsigned S_ID_WIDTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                                    hbm_clk,
    input  logic                                    hbm_areset,
    input  logic [NUM_REQ-1:0]                      s_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]           s_araddr,
    input  logic [NUM_REQ*S_ID_WIDTH-1:0]           s_arid,
    input  logic [NUM_REQ*4-1:0]                    s_arlen,
    output logic [NUM_REQ-1:0]                      s_arready,
    output logic                                    m_axi_ARVALID,
    output logic [ADDR_WIDTH-1:0]                   m_axi_ARADDR,
    output logic [S_ID_WIDTH+idx_w(NUM_REQ)-1:0]    m_axi_ARID,
    output logic [3:0]                              m_axi_ARLEN,
    input  logic                                    m_axi_ARREADY,
    input  logic                                    m_axi_RVALID,
    input  logic                                    m_axi_RREADY,
    input  logic                                    m_axi_RLAST,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
    output logic                                    cnt_err
`ifdef HBM_RD_ARB_DEBUG_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]                   grant_cnt,
    output logic [31:0]                             stall_cnt
`endif
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   win_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               credit_ok;
    logic               grant;
    logic               ar_hs;
    logic               r_done;

    hbm_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (s_arvalid),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign credit_ok = outstanding < OUT_W'(MAX_OUTSTANDING);
    // Reset gating keeps s_arready low while the state register is held in reset.
    assign grant     = (state_q == StArb) && pick_valid && credit_ok && !hbm_areset;
    assign ar_hs     = (state_q == StIssue) && m_axi_ARREADY;
    assign r_done    = m_axi_RVALID && m_axi_RREADY && m_axi_RLAST;

    always_comb begin
        s_arready = '0;
        if (grant) begin
            s_arready[pick_idx] = 1'b1;
        end
    end

    // Arbiter FSM; all AR outputs are registered and frozen while in StIssue.
    always_ff @(posedge hbm_clk or posedge hbm_areset) begin
        if (hbm_areset) begin
            state_q       <= StArb;
            rr_ptr_q      <= '0;
            win_q         <= '0;
            m_axi_ARVALID <= 1'b0;
            m_axi_ARADDR  <= '0;
            m_axi_ARID    <= '0;
            m_axi_ARLEN   <= '0;
        end else begin
            case (state_q)
                StArb: begin
                    if (grant) begin
                        win_q         <= pick_idx;
                        m_axi_ARVALID <= 1'b1;
                        m_axi_ARADDR  <= s_araddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        m_axi_ARID    <= {pick_idx, s_arid[pick_idx*S_ID_WIDTH +: S_ID_WIDTH]};
                        m_axi_ARLEN   <= s_arlen[pick_idx*4 +: 4];
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    if (m_axi_ARREADY) begin
                        m_axi_ARVALID <= 1'b0;
                        rr_ptr_q      <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                        state_q       <= StArb;
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    // In-flight burst credit; a simultaneous issue and completion cancel out.
    always_ff @(posedge hbm_clk or posedge hbm_areset) begin
        if (hbm_areset) begin
            outstanding <= '0;
            cnt_err     <= 1'b0;
        end else begin
            case ({ar_hs, r_done})
                2'b10: outstanding <= outstanding + 1'b1;
                2'b01: begin
                    if (outstanding == '0) begin
                        cnt_err <= 1'b1;
                    end else begin
                        outstanding <= outstanding - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HBM_RD_ARB_DEBUG_CNT_EN
    always_ff @(posedge hbm_clk or posedge hbm_areset) begin
        if (hbm_areset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned g = 0; g < NUM_REQ; g++) begin
                if (grant && (pick_idx == IDX_W'(g))) begin
                    grant_cnt[g*32 +: 32] <= grant_cnt[g*32 +: 32] + 32'd1;
                end
            end
            if ((state_q == StArb) && (|s_arvalid) && !credit_ok) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
